hazard_scoreboard: RTL

//  Parametrised forwarding/stall unit for the decode stage. Tracks in-flight register writes in a DEPTH-entry

---
 rtl/hazard_scoreboard_pkg.sv | 10 +
 rtl/scoreboard_match.sv | 31 +++
 rtl/hazard_scoreboard.sv | 98 +++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants for the forwarding/stall scoreboard
package hazard_scoreboard_pkg;

    // Forward-select code meaning "read the register file"
    localparam int FSEL_RF    = 0;
    // Entry index at which a result first becomes forwardable; the decoder drives id_avail_stg with these
    localparam int AVAIL_ALU  = 0;
    localparam int AVAIL_LOAD = 1;

endpackage

// File: rtl/scoreboard_match.sv
// rtl/scoreboard_match.sv - priority matcher returning the youngest in-flight writer of one operand
module scoreboard_match #(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int STG_W  = 2
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][REG_AW-1:0] dst_i,
    input  logic [DEPTH-1:0][STG_W-1:0]  avail_i,
    input  logic [REG_AW-1:0]            addr_i,
    input  logic                         used_i,
    output logic                         hit_o,
    output logic [STG_W-1:0]             idx_o,
    output logic                         hazard_o
);

    // Scan oldest to youngest so the lowest matching index is the one left standing
    always_comb begin
        hit_o    = 1'b0;
        idx_o    = '0;
        hazard_o = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_i[k] && used_i && (addr_i != '0) && (dst_i[k] == addr_i)) begin
                hit_o    = 1'b1;
                idx_o    = STG_W'(k);
                hazard_o = (STG_W'(k) < avail_i[k]);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage forwarding select, load-use stall and stall-cycle counter
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int STG_W  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_we,
    input  logic [REG_AW-1:0] id_dst_addr,
    input  logic [STG_W-1:0]  id_avail_stg,
    input  logic              flush_id,
    input  logic              hold,
    output logic              stall,
    output logic [STG_W-1:0]  rs_fwd_sel,
    output logic [STG_W-1:0]  rt_fwd_sel,
    output logic [CNT_W-1:0]  stall_count
);

    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
    logic [DEPTH-1:0][STG_W-1:0]  avl_q, avl_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic             rs_hit, rt_hit, rs_haz, rt_haz;
    logic [STG_W-1:0] rs_idx, rt_idx;

    scoreboard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .STG_W(STG_W)) u_rs_match (
        .valid_i (vld_q),
        .dst_i   (dst_q),
        .avail_i (avl_q),
        .addr_i  (id_rs_addr),
        .used_i  (id_rs_used),
        .hit_o   (rs_hit),
        .idx_o   (rs_idx),
        .hazard_o(rs_haz)
    );

    scoreboard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .STG_W(STG_W)) u_rt_match (
        .valid_i (vld_q),
        .dst_i   (dst_q),
        .avail_i (avl_q),
        .addr_i  (id_rt_addr),
        .used_i  (id_rt_used),
        .hit_o   (rt_hit),
        .idx_o   (rt_idx),
        .hazard_o(rt_haz)
    );

    assign stall       = id_valid & ~flush_id & (rs_haz | rt_haz);
    assign rs_fwd_sel  = (rs_hit && !rs_haz) ? rs_idx + STG_W'(1) : STG_W'(FSEL_RF);
    assign rt_fwd_sel  = (rt_hit && !rt_haz) ? rt_idx + STG_W'(1) : STG_W'(FSEL_RF);
    assign stall_count = cnt_q;

    // A stalled or flushed instruction never enters the scoreboard; a bubble takes its place
    always_comb begin
        vld_d    = vld_q;
        dst_d    = dst_q;
        avl_d    = avl_q;
        cnt_d    = cnt_q;
        if (!hold) begin
            vld_d[0] = id_valid & id_we & ~flush_id & ~stall & (id_dst_addr != '0);
            dst_d[0] = id_dst_addr;
            avl_d[0] = id_avail_stg;
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                dst_d[k] = dst_q[k-1];
                avl_d[k] = avl_q[k-1];
            end
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dst_q <= '0;
            avl_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            dst_q <= dst_d;
            avl_q <= avl_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
